// File: rtl/booth_dispatch_if.sv
// Operand-in / product-out stream bundle for booth_dispatch.
// The slave modport is the dispatcher side; the master modport is the
// surrounding logic that offers operand pairs and consumes products.
interface booth_dispatch_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product
  );
endinterface

// File: rtl/booth_dispatch.sv
// booth_dispatch: buffers operand pairs in a small FIFO, runs the BOOTHU
// start/done handshake one pair at a time and holds each product in a
// valid/ready output register until it is consumed.
// Optional feature: define BOOTH_DISPATCH_TIMEOUT_EN to add an ISSUE-state
// watchdog (TIMEOUT cycles) that abandons a stuck multiply and sets err.
module booth_dispatch #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  booth_dispatch_if.slave    io,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               busy,
  output logic               err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   fifo_a [DEPTH];
  logic [WIDTH-1:0]   fifo_b [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               out_valid_r;
  logic [2*WIDTH-1:0] out_product_r;
  logic               push, pop, capture, timeout_hit;

  // Handshake decodes; an issue needs a buffered pair, a free output
  // register and a multiplier that is not still signalling done.
  assign push    = io.in_valid && io.in_ready;
  assign pop     = (state == S_IDLE) && (count != '0) && !out_valid_r && !mul_done;
  assign capture = (state == S_ISSUE) && mul_done;

  assign io.in_ready    = (count != CW'(DEPTH));
  assign io.out_valid   = out_valid_r;
  assign io.out_product = out_product_r;

  // Operand storage is pure data: written on push, read at the head pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= io.in_a;
      fifo_b[wr_ptr] <= io.in_b;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: issue from IDLE, wait for done (or watchdog), then wait for done low.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (pop) state_nxt = S_ISSUE;
      S_ISSUE:   if (mul_done || timeout_hit) state_nxt = S_RELEASE;
      S_RELEASE: if (!mul_done) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: start is held for exactly the ISSUE state.
  always_comb begin
    mul_start = (state == S_ISSUE);
    busy      = (state != S_IDLE) || (count != '0);
  end

  // Operand registers toward the multiplier, loaded on the issue edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (pop) begin
      mul_a <= fifo_a[rd_ptr];
      mul_b <= fifo_b[rd_ptr];
    end
  end

  // Output register: capture the product on done, release on consumer accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r   <= 1'b0;
      out_product_r <= '0;
    end else if (capture) begin
      out_valid_r   <= 1'b1;
      out_product_r <= mul_product;
    end else if (out_valid_r && io.out_ready) begin
      out_valid_r   <= 1'b0;
    end
  end

`ifdef BOOTH_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  assign timeout_hit = (state == S_ISSUE) && !mul_done && (to_cnt == TW'(TIMEOUT - 1));

  // Watchdog: counts ISSUE cycles, restarts whenever ISSUE is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                to_cnt <= '0;
    else if (state != S_ISSUE) to_cnt <= '0;
    else                       to_cnt <= to_cnt + TW'(1);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           err <= 1'b0;
    else if (timeout_hit) err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif
endmodule

// File: tb/tb_booth_dispatch.sv
// Scoreboard bench for booth_dispatch with a behavioural BOOTHU stand-in
// (done is a one-cycle pulse a few cycles after start, product = A*B signed).
module tb_booth_dispatch;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mul_start, mul_done;
  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] mul_product;
  logic           busy, err;
  logic [3:0]     st_cnt;
  logic           st_fin;

  int             total = 0;
  int             bad = 0;
  logic [15:0]    exp_q[$];

  booth_dispatch_if #(.WIDTH(W)) bus();

  booth_dispatch #(.WIDTH(W), .DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .io(bus),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    return sa * sb;
  endfunction

  // Multiplier stand-in: latency of four start cycles, one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_done <= 1'b0; st_cnt <= '0; st_fin <= 1'b0; mul_product <= '0;
    end else if (!mul_start) begin
      mul_done <= 1'b0; st_cnt <= '0; st_fin <= 1'b0;
    end else if (st_fin) begin
      mul_done <= 1'b0;
    end else if (st_cnt == 4'd3) begin
      mul_done <= 1'b1; st_fin <= 1'b1; mul_product <= smul(mul_a, mul_b);
    end else begin
      st_cnt <= st_cnt + 4'd1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every accepted product is compared against the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_product got=%h exp=none", bus.out_product);
      end else begin
        chk("out_product", 32'(bus.out_product), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc1();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
    for (int i = 0; i < 200 && !bus.in_ready; i++) cyc1();
    chk("push_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    exp_q.push_back(e);
    cyc1();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_start(input logic v, input string nm);
    for (int i = 0; i < 200 && mul_start !== v; i++) cyc1();
    chk(nm, 32'(mul_start), 32'(v));
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 400 && (exp_q.size() != 0 || bus.out_valid); i++) cyc1();
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    repeat (3) cyc1();
    // reset state
    chk("rst_mul_start", 32'(mul_start), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_out_product", 32'(bus.out_product), 0);
    rst_n = 1'b1;
    cyc1();

    // 0x10 * 0x04: start latency, hold until done, capture edge
    push(8'h10, 8'h04, 16'h0040);
    chk("t1_start_not_yet", 32'(mul_start), 0);
    cyc1();
    chk("t1_start_rise", 32'(mul_start), 1);
    chk("t1_mul_a", 32'(mul_a), 32'h10);
    chk("t1_mul_b", 32'(mul_b), 32'h04);
    for (int i = 0; i < 200 && !mul_done; i++) cyc1();
    chk("t1_done_seen", 32'(mul_done), 1);
    chk("t1_start_held", 32'(mul_start), 1);
    cyc1();
    chk("t1_start_fall", 32'(mul_start), 0);
    chk("t1_out_valid", 32'(bus.out_valid), 1);
    chk("t1_out_product", 32'(bus.out_product), 32'h0040);
    bus.out_ready = 1'b1;
    wait_drain("t1_drain");

    // signed: -3 * 5
    push(8'hFD, 8'h05, 16'hFFF1);
    wait_drain("t2_drain");

    // backpressure: five pairs with consumer stalled
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push(8'(k), 8'(k), 16'(k * k));
    chk("t3_in_ready_full", 32'(bus.in_ready), 0);
    for (int i = 0; i < 200 && !bus.out_valid; i++) cyc1();
    repeat (5) cyc1();
    chk("t3_held_valid", 32'(bus.out_valid), 1);
    chk("t3_held_product", 32'(bus.out_product), 32'd1);
    chk("t3_no_issue", 32'(mul_start), 0);
    chk("t3_still_full", 32'(bus.in_ready), 0);
    chk("t3_busy", 32'(busy), 1);
    bus.out_ready = 1'b1;
    wait_drain("t3_drain");

    // asynchronous reset during ISSUE with a pair still buffered
    push(8'h03, 8'h03, 16'h0009);
    push(8'h04, 8'h02, 16'h0008);
    wait_start(1'b1, "t4_in_issue");
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_mul_start", 32'(mul_start), 0);
    chk("t4_rst_out_valid", 32'(bus.out_valid), 0);
    chk("t4_rst_busy", 32'(busy), 0);
    chk("t4_rst_in_ready", 32'(bus.in_ready), 1);
    chk("t4_rst_mul_a", 32'(mul_a), 0);
    exp_q.delete();
    cyc1();
    rst_n = 1'b1;
    repeat (3) cyc1();
    chk("t4_post_busy", 32'(busy), 0);
    chk("t4_post_start", 32'(mul_start), 0);

    // back-to-back issues with consumer always ready
    push(8'h02, 8'h03, 16'h0006);
    push(8'h07, 8'h07, 16'h0031);
    push(8'h7F, 8'h80, 16'hC080);
    for (int k = 0; k < 2; k++) begin
      wait_start(1'b1, "t5_start_high");
      wait_start(1'b0, "t5_start_fall");
      n = 0;
      while (!mul_start && n < 10) begin cyc1(); n++; end
      chk("t5_issue_gap", 32'(n), 32'd2);
    end
    wait_drain("t5_drain");
    chk("t5_err", 32'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/booth_dispatch.md
# booth_dispatch

- Operand dispatcher and result collector that sits directly in front of the `BOOTHU` Booth multiplier.
- Buffers incoming operand pairs in a small FIFO and drives the multiplier's `Start_sig`/`A`/`B` inputs one pair at a time, honouring its start/done handshake.
- Captures `Product` on `Done_sig` and presents it downstream through a valid/ready output register.
- Removes the need for the surrounding logic to hold `Start_sig` by hand until `Done_sig`.

## Interface
- `WIDTH`, default 8: operand width; must match the `BOOTHU` parameter.
- `DEPTH`, default 4: operand FIFO entries; power of two, ≥2.
- `TIMEOUT`, default 64: watchdog limit in cycles; used only with `BOOTH_DISPATCH_TIMEOUT_EN`.

Ports (clock and reset first):
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: FIFO not full.
- `in_a` in WIDTH: multiplicand.
- `in_b` in WIDTH: multiplier.
- `mul_start` out 1: to `BOOTHU Start_sig`.
- `mul_a` out WIDTH: to `BOOTHU A`.
- `mul_b` out WIDTH: to `BOOTHU B`.
- `mul_done` in 1: from `BOOTHU Done_sig`.
- `mul_product` in 2*WIDTH: from `BOOTHU Product`.
- `out_valid` out 1: `out_product` holds an unconsumed result.
- `out_ready` in 1: consumer accepts.
- `out_product` out 2*WIDTH: registered product, passed through bit-exact.
- `busy` out 1: state ≠ IDLE or FIFO non-empty.
- `err` out 1: sticky timeout flag.

## Operation
**FIFO**
- Write on `in_valid & in_ready`.
- `in_ready = (count != DEPTH)`, combinational from registered count.
- When full, `in_valid` is ignored; no overwrite.
- Pointers wrap modulo `DEPTH`.
- Pop occurs only on the IDLE→ISSUE transition.

**State machine: IDLE, ISSUE, RELEASE**
- IDLE → ISSUE when FIFO non-empty and `out_valid` = 0 and `mul_done` = 0.
  - On that edge, load head pair into `mul_a`/`mul_b`, set `mul_start` = 1, pop FIFO.
- ISSUE: hold `mul_start` = 1; `mul_a`/`mul_b` are stable.
  - When `mul_done` is sampled 1: `out_product ← mul_product`, `out_valid ← 1`, `mul_start ← 0`, go to RELEASE.
- RELEASE: `mul_start` = 0. Go to IDLE when `mul_done` is sampled 0.

**Output register**
- `out_valid` clears on `out_valid & out_ready`.
- `out_product` holds its value until the next capture.
- Only one product is in flight. A new issue requires `out_valid` = 0, so results are never dropped and stay in FIFO order.

**Simultaneous events**
- FIFO push and pop in the same cycle: count unchanged.
- Output drain and IDLE evaluation in the same cycle: issue waits one cycle, because the `out_valid` value in effect before that edge is 1.

**Reset**
- Asynchronous, effective immediately, including mid-operation.
- FIFO emptied; state = IDLE.
- `mul_start`, `mul_a`, `mul_b`, `out_valid`, `out_product`, `busy`, `err` = 0; `in_ready` = 1.
- The in-flight pair is discarded. `BOOTHU` shares `rst_n`, so both blocks restart consistently.

## Timing
- FIFO write at edge n → earliest `mul_start` high after edge n+1 (FIFO empty and IDLE).
- `mul_start` rises one cycle after the pop decision and stays high through the edge that samples `mul_done` = 1.
- `out_valid` rises at that same edge; `mul_start` falls at that edge.
- Earliest next `mul_start`:
  - one cycle after both `mul_done` = 0 is sampled in RELEASE and `out_valid` = 0;
  - with `out_ready` tied 1, that is 2 cycles after the done edge.
- Products are not altered; width is 2*WIDTH from the multiplier.

## Configuration
- `BOOTH_DISPATCH_TIMEOUT_EN` defined:
  - A counter runs in ISSUE.
  - If `mul_done` has not been seen after `TIMEOUT` cycles: `mul_start ← 0`, `err ← 1` (sticky until reset), go to RELEASE.
  - No product is written; the pair is lost.
- Not defined:
  - No counter; ISSUE waits indefinitely.
  - `err` tied 0.

## Test plan
- Reset, then push A = 0x10, B = 0x04 → `mul_start` held until `Done_sig`; `out_valid` = 1 with `out_product` = 0x0040; `mul_start` low the same edge.
- Push A = 0xFD (−3), B = 0x05 → `out_product` = 0xFFF1 (−15).
- `out_ready` = 0; push 5 pairs (1×1 … 5×5):
  - `in_ready` drops after the 5th push (1 issued, 4 buffered);
  - first result held;
  - releasing `out_ready` yields 1, 4, 9, 16, 25 in order.
- Assert `rst_n` = 0 during ISSUE → `mul_start`, `out_valid`, `busy` go 0 immediately; FIFO empty; `in_ready` = 1.
- Push with `out_ready` = 1 continuously → back-to-back issues separated by exactly 2 cycles after each done edge.
- With `BOOTH_DISPATCH_TIMEOUT_EN` and a stubbed multiplier that never asserts done → `mul_start` drops after 64 cycles, `err` = 1, next pair issued.
